watch_time_ctrl: RTL and testbench
==================================

// Module: watch_time_ctrl
// PURPOSE
//  Timekeeping controller for the ASIC watch. Consumes the 1 Hz tick derived from
//  the 32.768 kHz crystal divider and maintains hours/minutes/seconds. A mode/set
//  state machine lets the user set the time with two debounced buttons. Sits
//  between the crystal divider and the display driver.
// PARAMETERS
//  HOUR_MOD   24  hour counter modulus; hours count 0..HOUR_MOD-1 (legal: 12, 24)
// PORTS
//  clk_i       in   1  32.768 kHz system clock
//  rstn_i      in   1  reset, synchronous, active-low
//  tick_i      in   1  1 Hz strobe, high for exactly one clk_i cycle per second
//  btn_mode_i  in   1  mode button, debounced single-cycle pulse
//  btn_inc_i   in   1  increment button, debounced single-cycle pulse
//  sec_o       out  6  seconds, 0..59
//  min_o       out  6  minutes (or alarm minutes in SET_AMIN), 0..59
//  hour_o      out  5  hours (or alarm hours in SET_AHOUR), 0..HOUR_MOD-1
//  mode_o      out  3  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_AHOUR, 4 SET_AMIN
//  blink_o     out  1  toggles on each tick_i while not in RUN; 0 in RUN
//  alarm_o     out  1  alarm indication (see CONFIGURATION)
// BEHAVIOUR
//  - Reset is synchronous: the cycle after rstn_i=0 is sampled, all outputs are 0,
//    FSM is in RUN. Reset wins over every other input in the same cycle.
//  - All outputs are registered; every input takes effect on the next clk_i edge.
//  - RUN: each tick_i increments sec. 59->0 carries into min; min 59->0 carries
//    into hour; hour HOUR_MOD-1->0. All carries resolve in the same cycle.
//  - btn_inc_i is ignored in RUN.
//  - Mode cycle without the alarm: RUN->SET_HOUR->SET_MIN->RUN.
//  - RUN->SET_HOUR transition clears sec to 0. A tick_i in that same cycle is
//    discarded completely; min and hour receive no carry.
//  - SET_HOUR: btn_inc_i increments hour modulo HOUR_MOD.
//  - SET_MIN: btn_inc_i increments min modulo 60, with no carry into hour.
//  - Set states: tick_i does not advance time. Each tick_i toggles blink_o.
//  - Leaving a set state to RUN forces blink_o to 0. Counting resumes on the
//    first tick_i after the transition cycle.
//  - btn_mode_i and btn_inc_i high in the same cycle: the increment applies to
//    the current field, then the state advances.
//  - btn_mode_i and btn_inc_i are single-cycle pulses. Holding either high
//    advances or increments once per cycle; no edge detection is done.
//  - Out-of-range values cannot arise. The increment compare is against the
//    terminal value, never against a wrapped sum.
// CONFIGURATION
//  Macro ALARM_WATCH_EN:
//  - Defined: adds alarm hour/minute registers, reset to 0.
//  - Defined: mode cycle is RUN->SET_HOUR->SET_MIN->SET_AHOUR->SET_AMIN->RUN.
//  - Defined: SET_AHOUR/SET_AMIN increment the alarm hour/minute with the same
//    wrap rules as the time fields. In those states hour_o/min_o show the alarm
//    values and sec_o shows 0.
//  - Defined: alarm_o=1 (registered) while mode is RUN and hour/min equal the alarm
//    hour/min; it is therefore high for that whole minute. Otherwise alarm_o=0.
//  - Not defined: SET_MIN->RUN, mode_o never reaches 3 or 4, alarm_o is constant
//    0, and no alarm registers are built.
// TESTING
//  1. Reset: rstn_i=0 for one edge mid-count (12:34:56) -> next cycle all outputs 0,
//     mode_o=0.
//  2. Rollover, HOUR_MOD=24: load 23:59:59 and apply tick_i -> 00:00:00 one cycle
//     later. Same test with HOUR_MOD=12 from 11:59:59 -> 00:00:00.
//  3. Set: in RUN at 05:10:30, btn_mode_i -> mode_o=1, sec_o=0. Then 20x btn_inc_i
//     -> hour_o=1 (wraps at 24). Then btn_mode_i and 50x btn_inc_i from min 10
//     -> min_o=0, hour_o unchanged.
//  4. Simultaneous: tick_i and btn_mode_i in the same cycle at 05:10:59 -> 05:10:00,
//     mode_o=1, no carry. In SET_MIN, btn_inc_i and btn_mode_i together -> min+1
//     and mode_o=0.
//  5. Blink: in SET_HOUR apply 3 ticks -> blink_o toggles 0,1,0,1 and time stays
//     frozen. Return to RUN -> blink_o=0.
//  6. ALARM_WATCH_EN: set alarm to 07:00 and run from 06:59:59 -> alarm_o rises one
//     cycle after 07:00:00 is shown and falls after 07:01:00. Without the macro,
//     alarm_o stays 0 and the mode cycle length is 3.

Source files
------------

// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl: hh:mm:ss timekeeping with a RUN/set-mode FSM.
// Define ALARM_WATCH_EN to build the alarm set states and compare.
module watch_time_ctrl #(
    parameter int HOUR_MOD = 24
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       tick_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [4:0] hour_o,
    output logic [2:0] mode_o,
    output logic       blink_o,
    output logic       alarm_o
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_AHOUR = 3'd3,
        SET_AMIN  = 3'd4
    } mode_t;

    localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);

    mode_t      r_mode;
    mode_t      w_mode_n;
    logic [5:0] r_sec;
    logic [5:0] w_sec_n;
    logic [5:0] r_min;
    logic [5:0] w_min_n;
    logic [4:0] r_hour;
    logic [4:0] w_hour_n;
    logic       r_blink;
    logic       w_blink_n;

`ifdef ALARM_WATCH_EN
    logic [4:0] r_ahour;
    logic [4:0] w_ahour_n;
    logic [5:0] r_amin;
    logic [5:0] w_amin_n;
    logic       r_alarm;
    logic [5:0] r_dsec;
    logic [5:0] r_dmin;
    logic [4:0] r_dhour;
    logic       w_alarm_view;
`endif

    // Compare against the terminal value so a wrapped sum is never formed.
    function automatic logic [5:0] inc_60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    always_comb begin
        w_sec_n   = r_sec;
        w_min_n   = r_min;
        w_hour_n  = r_hour;
        w_mode_n  = r_mode;
        w_blink_n = r_blink;
`ifdef ALARM_WATCH_EN
        w_ahour_n = r_ahour;
        w_amin_n  = r_amin;
`endif
        unique case (r_mode)
            RUN: begin
                if (btn_mode_i) begin
                    w_sec_n  = 6'd0;
                    w_mode_n = SET_HOUR;
                end else if (tick_i) begin
                    w_sec_n = inc_60(r_sec);
                    if (r_sec == 6'd59) begin
                        w_min_n = inc_60(r_min);
                        if (r_min == 6'd59) begin
                            w_hour_n = inc_hour(r_hour);
                        end
                    end
                end
            end
            SET_HOUR: begin
                if (btn_inc_i) begin
                    w_hour_n = inc_hour(r_hour);
                end
                if (btn_mode_i) begin
                    w_mode_n = SET_MIN;
                end
            end
            SET_MIN: begin
                if (btn_inc_i) begin
                    w_min_n = inc_60(r_min);
                end
                if (btn_mode_i) begin
`ifdef ALARM_WATCH_EN
                    w_mode_n = SET_AHOUR;
`else
                    w_mode_n = RUN;
`endif
                end
            end
`ifdef ALARM_WATCH_EN
            SET_AHOUR: begin
                if (btn_inc_i) begin
                    w_ahour_n = inc_hour(r_ahour);
                end
                if (btn_mode_i) begin
                    w_mode_n = SET_AMIN;
                end
            end
            SET_AMIN: begin
                if (btn_inc_i) begin
                    w_amin_n = inc_60(r_amin);
                end
                if (btn_mode_i) begin
                    w_mode_n = RUN;
                end
            end
`endif
            default: begin
                w_mode_n = RUN;
            end
        endcase

        // Blink only toggles on ticks seen while already in a set state.
        if (w_mode_n == RUN) begin
            w_blink_n = 1'b0;
        end else if ((r_mode != RUN) && tick_i) begin
            w_blink_n = ~r_blink;
        end
    end

`ifdef ALARM_WATCH_EN
    assign w_alarm_view = (w_mode_n == SET_AHOUR) || (w_mode_n == SET_AMIN);
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_mode  <= RUN;
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_hour  <= 5'd0;
            r_blink <= 1'b0;
`ifdef ALARM_WATCH_EN
            r_ahour <= 5'd0;
            r_amin  <= 6'd0;
            r_alarm <= 1'b0;
            r_dsec  <= 6'd0;
            r_dmin  <= 6'd0;
            r_dhour <= 5'd0;
`endif
        end else begin
            r_mode  <= w_mode_n;
            r_sec   <= w_sec_n;
            r_min   <= w_min_n;
            r_hour  <= w_hour_n;
            r_blink <= w_blink_n;
`ifdef ALARM_WATCH_EN
            r_ahour <= w_ahour_n;
            r_amin  <= w_amin_n;
            r_alarm <= (r_mode == RUN) && (r_hour == r_ahour) && (r_min == r_amin);
            r_dsec  <= w_alarm_view ? 6'd0 : w_sec_n;
            r_dmin  <= w_alarm_view ? w_amin_n : w_min_n;
            r_dhour <= w_alarm_view ? w_ahour_n : w_hour_n;
`endif
        end
    end

    assign mode_o  = r_mode;
    assign blink_o = r_blink;
`ifdef ALARM_WATCH_EN
    assign sec_o   = r_dsec;
    assign min_o   = r_dmin;
    assign hour_o  = r_dhour;
    assign alarm_o = r_alarm;
`else
    assign sec_o   = r_sec;
    assign min_o   = r_min;
    assign hour_o  = r_hour;
    assign alarm_o = 1'b0;
`endif

endmodule

// File: tb/tb_watch_time_ctrl.sv
// tb_watch_time_ctrl: vector table, corner sequences and a random run
// against a seconds-of-day reference model, for HOUR_MOD 24 and 12.
module tb_watch_time_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn = 1'b0;
    logic tick = 1'b0;
    logic bm   = 1'b0;
    logic bi   = 1'b0;

    logic [5:0] s24, m24, s12, m12;
    logic [4:0] h24, h12;
    logic [2:0] md24, md12;
    logic       b24, b12, a24, a12;

    watch_time_ctrl #(.HOUR_MOD(24)) dut24 (
        .clk_i(clk), .rstn_i(rstn), .tick_i(tick),
        .btn_mode_i(bm), .btn_inc_i(bi),
        .sec_o(s24), .min_o(m24), .hour_o(h24),
        .mode_o(md24), .blink_o(b24), .alarm_o(a24)
    );

    watch_time_ctrl #(.HOUR_MOD(12)) dut12 (
        .clk_i(clk), .rstn_i(rstn), .tick_i(tick),
        .btn_mode_i(bm), .btn_inc_i(bi),
        .sec_o(s12), .min_o(m12), .hour_o(h12),
        .mode_o(md12), .blink_o(b12), .alarm_o(a12)
    );

`ifdef ALARM_WATCH_EN
    localparam bit ALM = 1'b1;
    localparam int NM  = 5;
`else
    localparam bit ALM = 1'b0;
    localparam int NM  = 3;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Time is kept as seconds since midnight; mode is an index in the cycle.
    typedef struct packed {
        int t;
        int mode;
        bit blink;
        int ah;
        int am;
        bit alarm;
    } mdl_t;

    mdl_t ms24, ms12;

    function automatic mdl_t step(mdl_t s, bit r, bit t, bit m, bit i, int hm);
        mdl_t n;
        int h, mi, sc;
        n = s;
        if (!r) begin
            n = '0;
            return n;
        end
        h  = s.t / 3600;
        mi = (s.t / 60) % 60;
        sc = s.t % 60;
        n.alarm = ALM && (s.mode == 0) && (h == s.ah) && (mi == s.am);
        case (s.mode)
            0: begin
                if (m) n.t = s.t - sc;
                else if (t) n.t = (s.t + 1) % (hm * 3600);
            end
            1: if (i) n.t = ((h + 1) % hm) * 3600 + mi * 60 + sc;
            2: if (i) n.t = h * 3600 + ((mi + 1) % 60) * 60 + sc;
            3: if (i) n.ah = (s.ah + 1) % hm;
            4: if (i) n.am = (s.am + 1) % 60;
            default: ;
        endcase
        if (m) n.mode = (s.mode + 1) % NM;
        if (n.mode == 0) n.blink = 1'b0;
        else if (s.mode != 0 && t) n.blink = !s.blink;
        return n;
    endfunction

    function automatic logic [21:0] exp_of(mdl_t s);
        int h, mi, sc;
        h  = s.t / 3600;
        mi = (s.t / 60) % 60;
        sc = s.t % 60;
        if (s.mode >= 3) begin
            h  = s.ah;
            mi = s.am;
            sc = 0;
        end
        return {6'(sc), 6'(mi), 5'(h), 3'(s.mode), s.blink, s.alarm};
    endfunction

    task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit m, input bit i);
        rstn = r;
        tick = t;
        bm   = m;
        bi   = i;
        @(posedge clk);
        ms24 = step(ms24, r, t, m, i, 24);
        ms12 = step(ms12, r, t, m, i, 12);
        #1;
        chk("model24", {s24, m24, h24, md24, b24, a24}, exp_of(ms24));
        chk("model12", {s12, m12, h12, md12, b12, a12}, exp_of(ms12));
    endtask

    typedef struct {
        bit r, t, m, i;
        int rep;
        int es, em, eh, emd;
        bit eb;
        int eh12;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(bit r, bit t, bit m, bit i, int rep,
                                 int es, int em, int eh, int emd, bit eb, int eh12);
        vec_t v;
        v.r = r; v.t = t; v.m = m; v.i = i; v.rep = rep;
        v.es = es; v.em = em; v.eh = eh; v.emd = emd; v.eb = eb;
        v.eh12 = eh12;
        return v;
    endfunction

    initial begin
        ms24 = '0;
        ms12 = '0;

        vq.push_back(mkv(0,0,0,0,1,   0, 0, 0,0,0,-1));
        vq.push_back(mkv(1,0,1,0,1,   0, 0, 0,1,0,-1));
        vq.push_back(mkv(1,0,0,1,5,   0, 0, 5,1,0,-1));
        vq.push_back(mkv(1,0,1,0,1,   0, 0, 5,2,0,-1));
        vq.push_back(mkv(1,0,0,1,10,  0,10, 5,2,0,-1));
        vq.push_back(mkv(1,0,1,0,NM-2,0,10, 5,0,0,-1));
        vq.push_back(mkv(1,0,0,1,5,   0,10, 5,0,0,-1));
        vq.push_back(mkv(1,1,0,0,30, 30,10, 5,0,0,-1));
        vq.push_back(mkv(1,0,1,0,1,   0,10, 5,1,0,-1));
        vq.push_back(mkv(1,0,0,1,20,  0,10, 1,1,0,-1));
        vq.push_back(mkv(1,0,1,0,1,   0,10, 1,2,0,-1));
        vq.push_back(mkv(1,0,0,1,50,  0, 0, 1,2,0,-1));
        vq.push_back(mkv(1,0,1,0,NM-2,0, 0, 1,0,0,-1));
        vq.push_back(mkv(1,1,0,0,59, 59, 0, 1,0,0,-1));
        vq.push_back(mkv(1,1,1,0,1,   0, 0, 1,1,0,-1));
        vq.push_back(mkv(1,1,0,0,1,   0, 0, 1,1,1,-1));
        vq.push_back(mkv(1,1,0,0,1,   0, 0, 1,1,0,-1));
        vq.push_back(mkv(1,1,0,0,1,   0, 0, 1,1,1,-1));
        vq.push_back(mkv(1,0,1,0,1,   0, 0, 1,2,1,-1));
`ifdef ALARM_WATCH_EN
        vq.push_back(mkv(1,0,1,1,1,   0, 0, 0,3,1,-1));
        vq.push_back(mkv(1,0,1,0,2,   0, 1, 1,0,0,-1));
`else
        vq.push_back(mkv(1,0,1,1,1,   0, 1, 1,0,0,-1));
`endif
        vq.push_back(mkv(1,1,0,0,1,   1, 1, 1,0,0,-1));
        vq.push_back(mkv(1,0,1,0,1,   0, 1, 1,1,0,-1));
        vq.push_back(mkv(1,0,1,0,1,   0, 1, 1,2,0,-1));
        vq.push_back(mkv(1,1,1,0,NM-2,0, 1, 1,0,0,-1));
        vq.push_back(mkv(1,1,0,0,1,   1, 1, 1,0,0,-1));
        vq.push_back(mkv(0,0,0,0,1,   0, 0, 0,0,0, 0));
        vq.push_back(mkv(1,0,1,0,1,   0, 0, 0,1,0,-1));
        vq.push_back(mkv(1,0,0,1,23,  0, 0,23,1,0,11));
        vq.push_back(mkv(1,0,1,0,1,   0, 0,23,2,0,-1));
        vq.push_back(mkv(1,0,0,1,59,  0,59,23,2,0,-1));
        vq.push_back(mkv(1,0,1,0,NM-2,0,59,23,0,0,-1));
        vq.push_back(mkv(1,1,0,0,59, 59,59,23,0,0,11));
        vq.push_back(mkv(1,1,0,0,1,   0, 0, 0,0,0, 0));
        vq.push_back(mkv(1,0,1,0,1,   0, 0, 0,1,0,-1));
        vq.push_back(mkv(1,0,0,1,12,  0, 0,12,1,0,-1));
        vq.push_back(mkv(1,0,1,0,1,   0, 0,12,2,0,-1));
        vq.push_back(mkv(1,0,0,1,34,  0,34,12,2,0,-1));
        vq.push_back(mkv(1,0,1,0,NM-2,0,34,12,0,0,-1));
        vq.push_back(mkv(1,1,0,0,56, 56,34,12,0,0,-1));
        vq.push_back(mkv(0,1,1,1,1,   0, 0, 0,0,0, 0));

        for (int k = 0; k < vq.size(); k++) begin
            for (int j = 0; j < vq[k].rep; j++) begin
                cyc(vq[k].r, vq[k].t, vq[k].m, vq[k].i);
            end
            chk($sformatf("vec%0d", k), {1'b0, s24, m24, h24, md24, b24},
                {1'b0, 6'(vq[k].es), 6'(vq[k].em), 5'(vq[k].eh),
                 3'(vq[k].emd), vq[k].eb});
            if (vq[k].eh12 >= 0) begin
                chk($sformatf("vec%0d_h12", k), 22'(h12), 22'(vq[k].eh12));
            end
        end

`ifdef ALARM_WATCH_EN
        cyc(1,0,1,0);
        repeat (6) cyc(1,0,0,1);
        cyc(1,0,1,0);
        repeat (59) cyc(1,0,0,1);
        cyc(1,0,1,0);
        repeat (7) cyc(1,0,0,1);
        cyc(1,0,1,0);
        cyc(1,0,1,0);
        repeat (59) cyc(1,1,0,0);
        chk("alm_before", 22'(a24), 22'(0));
        cyc(1,1,0,0);
        chk("alm_0700_time", {11'd0, h24, m24}, {11'd0, 5'd7, 6'd0});
        chk("alm_0700_lag", 22'(a24), 22'(0));
        cyc(1,0,0,0);
        chk("alm_rise", 22'(a24), 22'(1));
        repeat (60) cyc(1,1,0,0);
        chk("alm_0701_hold", 22'(a24), 22'(1));
        cyc(1,0,0,0);
        chk("alm_fall", 22'(a24), 22'(0));
`else
        repeat (3) cyc(1,0,1,0);
        chk("cycle_len3", 22'(md24), 22'(0));
        chk("alarm_off", 22'(a24), 22'(0));
`endif

        cyc(0,0,0,0);
        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 299) != 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
